multicycle_control_fsm: RTL and testbench

- Sequencing control unit for the multi-cycle core. It replaces the single-cycle combinational main decoder.
- Walks each instruction through FETCH / DECODE / EXEC / MEM / WB and handshakes with instruction and data memories of variable latency.
- Drives the same datapath control set (ImmSel, ALUSrcA/B, ALUOp, WBSel, RegWrite, mem strobes) per state, using core_pkg enums and OPCODE_* constants.
- Adds PC/IR write enables, a bus-timeout watchdog and a sticky trap state.

---
 rtl/multicycle_control_fsm.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with bus watchdog and sticky trap
// Define PERF_CNT_EN to add the cycle and retired-instruction counters.
package core_pkg;
   localparam logic [6:0] OPCODE_RTYPE  = 7'b0110011;
   localparam logic [6:0] OPCODE_ITYPE  = 7'b0010011;
   localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
   localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
   localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
   localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
   localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
   localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
   localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;

   typedef enum logic [2:0] {
      IMM_RTYPE, IMM_ITYPE, IMM_STYPE, IMM_BTYPE, IMM_UTYPE, IMM_JTYPE
   } imm_sel_e;

   typedef enum logic [2:0] {
      ALUOP_NONE, ALU_ADD, ALU_SUB, ALU_PASS_B, ALUOP_FUNCT3, ALUOP_FUNCT7
   } alu_op_e;

   typedef enum logic [1:0] {
      WB_NONE, WB_ALU, WB_MEM, WB_PC4
   } wb_sel_e;
endpackage

module multicycle_control_fsm
   import core_pkg::*;
#(
   parameter int MAX_WAIT = 16,
   parameter int WAIT_W   = $clog2(MAX_WAIT + 1),
   parameter int CNT_W    = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [6:0]       opcode_i,
   input  logic             branch_taken_i,
   output logic             imem_req_o,
   input  logic             imem_rvalid_i,
   output logic             dmem_req_o,
   input  logic             dmem_rvalid_i,
   output logic             MemRead_o,
   output logic             MemWrite_o,
   output logic             IRWrite_o,
   output logic             PCWrite_o,
   output logic [1:0]       pc_sel_o,
   output imm_sel_e         ImmSel_o,
   output logic             ALUSrcA_o,
   output logic             ALUSrcB_o,
   output alu_op_e          ALUOp_o,
   output logic             RegWrite_o,
   output wb_sel_e          WBSel_o,
   output logic             trap_o,
   output logic [1:0]       trap_cause_o,
   output logic [CNT_W-1:0] cycle_cnt_o,
   output logic [CNT_W-1:0] instret_o
);
   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
   } state_e;

   state_e            state_q, state_d;
   logic [6:0]        opcode_q, opcode_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic [1:0]        trap_cause_q, trap_cause_d;
   logic [WAIT_W-1:0] wait_inc;
   logic              timeout;

   imm_sel_e dec_imm;
   alu_op_e  dec_alu;
   wb_sel_e  dec_wb;
   logic     dec_src_a, dec_src_b;

   function automatic logic is_legal(input logic [6:0] op);
      case (op)
         OPCODE_RTYPE, OPCODE_ITYPE, OPCODE_LOAD, OPCODE_STORE, OPCODE_BRANCH,
         OPCODE_JAL, OPCODE_JALR, OPCODE_LUI, OPCODE_AUIPC: is_legal = 1'b1;
         default: is_legal = 1'b0;
      endcase
   endfunction

   // Datapath controls come from the latched opcode so a changing IR input cannot glitch them.
   always_comb begin
      dec_imm   = IMM_RTYPE;
      dec_alu   = ALUOP_NONE;
      dec_wb    = WB_NONE;
      dec_src_a = 1'b0;
      dec_src_b = 1'b0;
      case (opcode_q)
         OPCODE_RTYPE: begin
            dec_alu = ALUOP_FUNCT7;
            dec_wb  = WB_ALU;
         end
         OPCODE_ITYPE: begin
            dec_imm   = IMM_ITYPE;
            dec_alu   = ALUOP_FUNCT3;
            dec_src_b = 1'b1;
            dec_wb    = WB_ALU;
         end
         OPCODE_LOAD: begin
            dec_imm   = IMM_ITYPE;
            dec_alu   = ALU_ADD;
            dec_src_b = 1'b1;
            dec_wb    = WB_MEM;
         end
         OPCODE_STORE: begin
            dec_imm   = IMM_STYPE;
            dec_alu   = ALU_ADD;
            dec_src_b = 1'b1;
         end
         OPCODE_BRANCH: begin
            dec_imm = IMM_BTYPE;
            dec_alu = ALU_SUB;
         end
         OPCODE_JAL: begin
            dec_imm   = IMM_JTYPE;
            dec_alu   = ALU_ADD;
            dec_src_a = 1'b1;
            dec_src_b = 1'b1;
            dec_wb    = WB_PC4;
         end
         OPCODE_JALR: begin
            dec_imm   = IMM_ITYPE;
            dec_alu   = ALU_ADD;
            dec_src_b = 1'b1;
            dec_wb    = WB_PC4;
         end
         OPCODE_LUI: begin
            dec_imm   = IMM_UTYPE;
            dec_alu   = ALU_PASS_B;
            dec_src_a = 1'b1;
            dec_src_b = 1'b1;
            dec_wb    = WB_ALU;
         end
         OPCODE_AUIPC: begin
            dec_imm   = IMM_UTYPE;
            dec_alu   = ALU_ADD;
            dec_src_a = 1'b1;
            dec_src_b = 1'b1;
            dec_wb    = WB_ALU;
         end
         default: ;
      endcase
   end

   assign wait_inc = wait_cnt_q + WAIT_W'(1);
   assign timeout  = (wait_inc == WAIT_W'(MAX_WAIT));

   // wait_cnt defaults to zero so it is clear on every entry to FETCH/MEM.
   always_comb begin
      state_d      = state_q;
      opcode_d     = opcode_q;
      wait_cnt_d   = '0;
      trap_cause_d = trap_cause_q;
      imem_req_o   = 1'b0;
      dmem_req_o   = 1'b0;
      MemRead_o    = 1'b0;
      MemWrite_o   = 1'b0;
      IRWrite_o    = 1'b0;
      PCWrite_o    = 1'b0;
      pc_sel_o     = 2'd0;
      ImmSel_o     = IMM_RTYPE;
      ALUSrcA_o    = 1'b0;
      ALUSrcB_o    = 1'b0;
      ALUOp_o      = ALUOP_NONE;
      RegWrite_o   = 1'b0;
      WBSel_o      = WB_NONE;
      trap_o       = 1'b0;
      trap_cause_o = 2'd0;
      // Outputs are gated by the raw reset so requests drop the instant reset asserts.
      if (rst_ni) begin
         trap_o       = (state_q == S_TRAP);
         trap_cause_o = trap_cause_q;
         if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
            ImmSel_o  = dec_imm;
            ALUSrcA_o = dec_src_a;
            ALUSrcB_o = dec_src_b;
            ALUOp_o   = dec_alu;
            WBSel_o   = dec_wb;
         end
         case (state_q)
            S_FETCH: begin
               imem_req_o = 1'b1;
               if (imem_rvalid_i) begin
                  IRWrite_o = 1'b1;
                  state_d   = S_DECODE;
               end else if (timeout) begin
                  state_d      = S_TRAP;
                  trap_cause_d = 2'd2;
               end else begin
                  wait_cnt_d = wait_inc;
               end
            end
            S_DECODE: begin
               opcode_d = opcode_i;
               if (is_legal(opcode_i)) begin
                  state_d = S_EXEC;
               end else begin
                  state_d      = S_TRAP;
                  trap_cause_d = 2'd1;
               end
            end
            S_EXEC: begin
               if (opcode_q == OPCODE_BRANCH) begin
                  PCWrite_o = 1'b1;
                  pc_sel_o  = branch_taken_i ? 2'd1 : 2'd0;
                  state_d   = S_FETCH;
               end else if (opcode_q == OPCODE_LOAD || opcode_q == OPCODE_STORE) begin
                  state_d = S_MEM;
               end else begin
                  state_d = S_WB;
               end
            end
            S_MEM: begin
               dmem_req_o = 1'b1;
               MemRead_o  = (opcode_q == OPCODE_LOAD);
               MemWrite_o = (opcode_q == OPCODE_STORE);
               if (dmem_rvalid_i) begin
                  if (opcode_q == OPCODE_LOAD) begin
                     state_d = S_WB;
                  end else begin
                     PCWrite_o = 1'b1;
                     state_d   = S_FETCH;
                  end
               end else if (timeout) begin
                  state_d      = S_TRAP;
                  trap_cause_d = 2'd3;
               end else begin
                  wait_cnt_d = wait_inc;
               end
            end
            S_WB: begin
               RegWrite_o = 1'b1;
               PCWrite_o  = 1'b1;
               if (opcode_q == OPCODE_JAL) begin
                  pc_sel_o = 2'd1;
               end else if (opcode_q == OPCODE_JALR) begin
                  pc_sel_o = 2'd2;
               end
               state_d = S_FETCH;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= S_FETCH;
         opcode_q     <= '0;
         wait_cnt_q   <= '0;
         trap_cause_q <= 2'd0;
      end else begin
         state_q      <= state_d;
         opcode_q     <= opcode_d;
         wait_cnt_q   <= wait_cnt_d;
         trap_cause_q <= trap_cause_d;
      end
   end

`ifdef PERF_CNT_EN
   logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
   logic [CNT_W-1:0] instret_q, instret_d;

   always_comb begin
      cycle_cnt_d = cycle_cnt_q;
      instret_d   = instret_q;
      if (state_q != S_TRAP) begin
         cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
      end
      if (PCWrite_o) begin
         instret_d = instret_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cycle_cnt_q <= '0;
         instret_q   <= '0;
      end else begin
         cycle_cnt_q <= cycle_cnt_d;
         instret_q   <= instret_d;
      end
   end

   assign cycle_cnt_o = cycle_cnt_q;
   assign instret_o   = instret_q;
`else
   assign cycle_cnt_o = '0;
   assign instret_o   = '0;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - directed self-checking bench for multicycle_control_fsm
module tb_multicycle_control_fsm;
   import core_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic [6:0]  opcode_i;
   logic        branch_taken_i;
   logic        imem_req_o, imem_rvalid_i;
   logic        dmem_req_o, dmem_rvalid_i;
   logic        MemRead_o, MemWrite_o, IRWrite_o, PCWrite_o;
   logic [1:0]  pc_sel_o;
   imm_sel_e    ImmSel_o;
   logic        ALUSrcA_o, ALUSrcB_o;
   alu_op_e     ALUOp_o;
   logic        RegWrite_o;
   wb_sel_e     WBSel_o;
   logic        trap_o;
   logic [1:0]  trap_cause_o;
   logic [31:0] cycle_cnt_o, instret_o;

   int passed = 0;
   int total  = 0;

   int      r_cyc, r_ireq, r_dreq, r_irw, r_rw, r_clash, r_mrd, r_mwr, r_pcw, r_pcsel, r_srcb;
   wb_sel_e r_wb;
   alu_op_e r_alu;

   multicycle_control_fsm dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .opcode_i(opcode_i), .branch_taken_i(branch_taken_i),
      .imem_req_o(imem_req_o), .imem_rvalid_i(imem_rvalid_i),
      .dmem_req_o(dmem_req_o), .dmem_rvalid_i(dmem_rvalid_i),
      .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o), .IRWrite_o(IRWrite_o), .PCWrite_o(PCWrite_o),
      .pc_sel_o(pc_sel_o), .ImmSel_o(ImmSel_o), .ALUSrcA_o(ALUSrcA_o), .ALUSrcB_o(ALUSrcB_o),
      .ALUOp_o(ALUOp_o), .RegWrite_o(RegWrite_o), .WBSel_o(WBSel_o), .trap_o(trap_o),
      .trap_cause_o(trap_cause_o), .cycle_cnt_o(cycle_cnt_o), .instret_o(instret_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
   endtask

   task automatic tick;
      @(posedge clk_i);
      #2;
   endtask

   // Runs one instruction from its FETCH cycle until PCWrite or trap; memories answer after idly/ddly request cycles.
   task automatic run_instr(input logic [6:0] op, input logic taken, input int idly, input int ddly);
      opcode_i = op;
      branch_taken_i = taken;
      r_cyc = 0; r_ireq = 0; r_dreq = 0; r_irw = 0; r_rw = 0; r_clash = 0;
      r_mrd = 0; r_mwr = 0; r_pcw = 0; r_pcsel = 0; r_srcb = 0;
      r_wb = WB_NONE; r_alu = ALUOP_NONE;
      for (int i = 0; i < 60; i++) begin
         imem_rvalid_i = (r_ireq >= idly);
         dmem_rvalid_i = (r_dreq >= ddly);
         #1;
         r_cyc++;
         if (imem_req_o) r_ireq++;
         if (dmem_req_o) begin
            r_dreq++;
            r_mrd = r_mrd | int'(MemRead_o);
            r_mwr = r_mwr | int'(MemWrite_o);
         end
         if (IRWrite_o) r_irw++;
         if (RegWrite_o) begin
            r_rw++;
            r_wb   = WBSel_o;
            r_srcb = int'(ALUSrcB_o);
         end
         if ((imem_req_o && dmem_req_o) || (PCWrite_o && IRWrite_o)) r_clash++;
         if (PCWrite_o || trap_o) begin
            r_pcw   = int'(PCWrite_o);
            r_pcsel = int'(pc_sel_o);
            r_alu   = ALUOp_o;
            break;
         end
         tick();
      end
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1);
   end

   initial begin
      rst_ni = 1'b0; opcode_i = '0; branch_taken_i = 1'b0;
      imem_rvalid_i = 1'b0; dmem_rvalid_i = 1'b0;
      repeat (3) tick();
      chk("rst_imem_req", 32'(imem_req_o), 0);
      chk("rst_pcwrite", 32'(PCWrite_o), 0);
      chk("rst_immsel", 32'(ImmSel_o), 32'(IMM_RTYPE));
      chk("rst_aluop", 32'(ALUOp_o), 32'(ALUOP_NONE));
      chk("rst_wbsel", 32'(WBSel_o), 32'(WB_NONE));
      chk("rst_trap", 32'(trap_o), 0);
      rst_ni = 1'b1;
      #1;
      chk("post_rst_imem_req", 32'(imem_req_o), 1);

      run_instr(OPCODE_RTYPE, 1'b0, 0, 0);
      chk("add_cycles", 32'(r_cyc), 4);
      chk("add_wbsel", 32'(r_wb), 32'(WB_ALU));
      chk("add_aluop", 32'(r_alu), 32'(ALUOP_FUNCT7));
      chk("add_pcsel", 32'(r_pcsel), 0);
      chk("add_irw", 32'(r_irw), 1);

      run_instr(OPCODE_LOAD, 1'b0, 0, 0);
      chk("lw_cycles", 32'(r_cyc), 5);
      chk("lw_regwrite", 32'(r_rw), 1);
      chk("lw_wbsel", 32'(r_wb), 32'(WB_MEM));
      chk("lw_memread", 32'(r_mrd), 1);
      chk("lw_aluop", 32'(r_alu), 32'(ALU_ADD));

      run_instr(OPCODE_STORE, 1'b0, 0, 0);
      chk("sw_cycles", 32'(r_cyc), 4);
      chk("sw_regwrite", 32'(r_rw), 0);
      chk("sw_memwrite", 32'(r_mwr), 1);
      chk("sw_memread", 32'(r_mrd), 0);
      chk("sw_clash", 32'(r_clash), 0);

      run_instr(OPCODE_BRANCH, 1'b1, 0, 0);
      chk("beq_cycles", 32'(r_cyc), 3);
      chk("beq_pcsel", 32'(r_pcsel), 1);
      chk("beq_aluop", 32'(r_alu), 32'(ALU_SUB));
      chk("beq_regwrite", 32'(r_rw), 0);
`ifdef PERF_CNT_EN
      chk("instret_after_4", instret_o, 4);
      chk("cycle_cnt_after_4", cycle_cnt_o, 16);
`else
      chk("instret_tied", instret_o, 0);
      chk("cycle_cnt_tied", cycle_cnt_o, 0);
`endif

      run_instr(OPCODE_RTYPE, 1'b0, 5, 0);
      chk("slow_imem_cycles", 32'(r_cyc), 9);
      chk("slow_imem_req_cycles", 32'(r_ireq), 6);
      chk("slow_imem_irw", 32'(r_irw), 1);
      chk("slow_imem_trap", 32'(trap_o), 0);

      run_instr(OPCODE_JALR, 1'b0, 0, 0);
      chk("jalr_cycles", 32'(r_cyc), 4);
      chk("jalr_wbsel", 32'(r_wb), 32'(WB_PC4));
      chk("jalr_pcsel", 32'(r_pcsel), 2);
      chk("jalr_srcb", 32'(r_srcb), 1);

      run_instr(OPCODE_JAL, 1'b0, 0, 0);
      chk("jal_pcsel", 32'(r_pcsel), 1);

      run_instr(OPCODE_BRANCH, 1'b0, 0, 0);
      chk("bne_cycles", 32'(r_cyc), 3);
      chk("bne_pcsel", 32'(r_pcsel), 0);

      run_instr(OPCODE_LOAD, 1'b0, 0, 1000);
      chk("to_cycles", 32'(r_cyc), 20);
      chk("to_dreq_cycles", 32'(r_dreq), 16);
      chk("to_regwrite", 32'(r_rw), 0);
      chk("to_pcwrite", 32'(r_pcw), 0);
      chk("to_trap", 32'(trap_o), 1);
      chk("to_cause", 32'(trap_cause_o), 3);
      chk("to_dmem_req", 32'(dmem_req_o), 0);
      imem_rvalid_i = 1'b1; dmem_rvalid_i = 1'b1;
      repeat (5) tick();
      chk("to_sticky_trap", 32'(trap_o), 1);
      chk("to_sticky_imem", 32'(imem_req_o), 0);

      rst_ni = 1'b0;
      #1;
      chk("rst_clears_trap", 32'(trap_o), 0);
      chk("rst_clears_cause", 32'(trap_cause_o), 0);
      tick();
      rst_ni = 1'b1;

      run_instr(7'b0000000, 1'b0, 0, 0);
      chk("ill_cycles", 32'(r_cyc), 3);
      chk("ill_cause", 32'(trap_cause_o), 1);
      r_ireq = 0;
      for (int i = 0; i < 4; i++) begin
         if (imem_req_o) r_ireq++;
         tick();
      end
      chk("ill_no_fetch", 32'(r_ireq), 0);

      rst_ni = 1'b0;
      tick();
      rst_ni = 1'b1;
      opcode_i = OPCODE_STORE;
      imem_rvalid_i = 1'b1; dmem_rvalid_i = 1'b0;
      repeat (3) tick();
      chk("mid_mem_dreq", 32'(dmem_req_o), 1);
      chk("mid_mem_write", 32'(MemWrite_o), 1);
      rst_ni = 1'b0;
      #1;
      chk("async_drop_dreq", 32'(dmem_req_o), 0);
      chk("async_drop_write", 32'(MemWrite_o), 0);
      chk("async_no_ireq", 32'(imem_req_o), 0);
      tick();
      imem_rvalid_i = 1'b0; dmem_rvalid_i = 1'b1;
      rst_ni = 1'b1;
      #1;
      chk("restart_ireq", 32'(imem_req_o), 1);
      chk("restart_dreq", 32'(dmem_req_o), 0);
      tick();
      chk("late_ack_pcwrite", 32'(PCWrite_o), 0);
      chk("late_ack_still_fetch", 32'(imem_req_o), 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
